// File: rtl/dma_rd_desc_queue_if.sv
// dma_rd_desc_queue_if: caller descriptor in, caller status out, DMA descriptor out and DMA status in; slave = queue side, master = caller/DMA side
interface dma_rd_desc_queue_if #(
  parameter int PCIE_ADDR_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int LEN_WIDTH = 20,
  parameter int S_TAG_WIDTH = 8,
  parameter int M_TAG_WIDTH = 8
);
  logic [PCIE_ADDR_WIDTH-1:0] s_axis_desc_pcie_addr;
  logic [AXI_ADDR_WIDTH-1:0] s_axis_desc_axi_addr;
  logic [LEN_WIDTH-1:0] s_axis_desc_len;
  logic [S_TAG_WIDTH-1:0] s_axis_desc_tag;
  logic s_axis_desc_valid;
  logic s_axis_desc_ready;
  logic [S_TAG_WIDTH-1:0] m_axis_desc_status_tag;
  logic m_axis_desc_status_valid;
  logic [PCIE_ADDR_WIDTH-1:0] m_axis_read_desc_pcie_addr;
  logic [AXI_ADDR_WIDTH-1:0] m_axis_read_desc_axi_addr;
  logic [LEN_WIDTH-1:0] m_axis_read_desc_len;
  logic [M_TAG_WIDTH-1:0] m_axis_read_desc_tag;
  logic m_axis_read_desc_valid;
  logic m_axis_read_desc_ready;
  logic [M_TAG_WIDTH-1:0] s_axis_read_desc_status_tag;
  logic s_axis_read_desc_status_valid;
  modport slave (
    input  s_axis_desc_pcie_addr, s_axis_desc_axi_addr, s_axis_desc_len, s_axis_desc_tag, s_axis_desc_valid,
    output s_axis_desc_ready,
    output m_axis_desc_status_tag, m_axis_desc_status_valid,
    output m_axis_read_desc_pcie_addr, m_axis_read_desc_axi_addr, m_axis_read_desc_len, m_axis_read_desc_tag, m_axis_read_desc_valid,
    input  m_axis_read_desc_ready,
    input  s_axis_read_desc_status_tag, s_axis_read_desc_status_valid
  );
  modport master (
    output s_axis_desc_pcie_addr, s_axis_desc_axi_addr, s_axis_desc_len, s_axis_desc_tag, s_axis_desc_valid,
    input  s_axis_desc_ready,
    input  m_axis_desc_status_tag, m_axis_desc_status_valid,
    input  m_axis_read_desc_pcie_addr, m_axis_read_desc_axi_addr, m_axis_read_desc_len, m_axis_read_desc_tag, m_axis_read_desc_valid,
    output m_axis_read_desc_ready,
    output s_axis_read_desc_status_tag, s_axis_read_desc_status_valid
  );
endinterface

// File: rtl/dma_rd_desc_queue.sv
// dma_rd_desc_queue: FIFO-buffered read descriptors issued to the DMA under a slot tag, with out-of-order status remapped to caller tags (ports: clk, active-low sync rst, enable, bus, fifo_count, outstanding_count, status_error)
module dma_rd_desc_queue #(
  parameter int PCIE_ADDR_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int LEN_WIDTH = 20,
  parameter int S_TAG_WIDTH = 8,
  parameter int M_TAG_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  dma_rd_desc_queue_if.slave bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_count,
  output logic status_error
);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int FC = FW + 1;
  localparam int SW = $clog2(MAX_OUTSTANDING);
  localparam int SC = SW + 1;
  localparam int DW = PCIE_ADDR_WIDTH + AXI_ADDR_WIDTH + LEN_WIDTH + S_TAG_WIDTH;
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [S_TAG_WIDTH-1:0] slot_tag [MAX_OUTSTANDING];
  logic [FW:0] wr_ptr, rd_ptr;
  logic [MAX_OUTSTANDING-1:0] busy;
  logic [SW-1:0] free_idx, st_idx;
  logic [DW-1:0] head;
  logic full, empty, push, load, st_ok;
  assign full = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign bus.s_axis_desc_ready = !full;
  assign push = bus.s_axis_desc_valid && !full;
  assign load = (!bus.m_axis_read_desc_valid || bus.m_axis_read_desc_ready) && !empty && !(&busy) && enable;
  assign head = mem[rd_ptr[FW-1:0]];
  assign st_idx = bus.s_axis_read_desc_status_tag[SW-1:0];
  // any tag bit above the slot index range makes the tag out of range
  assign st_ok = bus.s_axis_read_desc_status_valid && ((bus.s_axis_read_desc_status_tag >> SW) == '0) && busy[st_idx];
  always_comb begin
    free_idx = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) free_idx = busy[i] ? free_idx : SW'(i);
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FW-1:0]] <= {bus.s_axis_desc_pcie_addr, bus.s_axis_desc_axi_addr, bus.s_axis_desc_len, bus.s_axis_desc_tag};
    if (load) slot_tag[free_idx] <= head[S_TAG_WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      busy <= '0;
      fifo_count <= '0;
      outstanding_count <= '0;
      status_error <= 1'b0;
      bus.m_axis_read_desc_valid <= 1'b0;
      bus.m_axis_read_desc_pcie_addr <= '0;
      bus.m_axis_read_desc_axi_addr <= '0;
      bus.m_axis_read_desc_len <= '0;
      bus.m_axis_read_desc_tag <= '0;
      bus.m_axis_desc_status_valid <= 1'b0;
      bus.m_axis_desc_status_tag <= '0;
    end else begin
      wr_ptr <= wr_ptr + FC'(push);
      rd_ptr <= rd_ptr + FC'(load);
      fifo_count <= fifo_count + FC'(push) - FC'(load);
      // free and allocate never hit the same slot: one needs it busy, the other free
      busy <= (busy & ~(MAX_OUTSTANDING'(st_ok) << st_idx)) | (MAX_OUTSTANDING'(load) << free_idx);
      outstanding_count <= outstanding_count + SC'(load) - SC'(st_ok);
      status_error <= bus.s_axis_read_desc_status_valid && !st_ok;
      bus.m_axis_desc_status_valid <= st_ok;
      bus.m_axis_desc_status_tag <= st_ok ? slot_tag[st_idx] : '0;
      if (load) begin
        {bus.m_axis_read_desc_pcie_addr, bus.m_axis_read_desc_axi_addr, bus.m_axis_read_desc_len} <= head[DW-1:S_TAG_WIDTH];
        bus.m_axis_read_desc_tag <= M_TAG_WIDTH'(free_idx);
        bus.m_axis_read_desc_valid <= 1'b1;
      end else if (bus.m_axis_read_desc_ready) begin
        bus.m_axis_read_desc_valid <= 1'b0;
      end
    end
  end
endmodule
